// File: rtl/bk_limb_seq_adder.sv
// bk_limb_seq_adder
//   Wide add/subtract sequencer feeding an external 16-bit combinational
//   Brent-Kung adder core one limb per cycle. The carry is chained through a
//   register and the limbs are assembled into a W = 16*LIMBS bit result.
//   Only one transaction is in flight at a time.
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready         operand request handshake (ready only in IDLE)
//   in_a, in_b, in_cin        operands and carry-in (cin ignored for subtract)
//   in_sub                    1: A-B, 0: A+B+cin
//   out_valid/out_ready       result handshake
//   out_sum, out_cout, out_ovf  result, carry out of MSB, signed overflow
//   add_a/add_b/add_cin       limb operands to the adder core (0 when idle)
//   add_sum/add_cout          combinational result from the adder core
module bk_limb_seq_adder #(
  parameter  int LIMBS = 4,
  localparam int W     = 16*LIMBS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  input  logic         in_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic [15:0]  add_a,
  output logic [15:0]  add_b,
  output logic         add_cin,
  input  logic [15:0]  add_sum,
  input  logic         add_cout
);
  localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

  logic [1:0]              state;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic [LIMBS-1:0][15:0]  a_l, b_l, res, nxt_res;
  logic                    last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (idx == IW'(LIMBS-1));

  // Working result with the current limb merged in; on the final limb this
  // is the complete sum, written to out_sum so out_sum only ever changes on
  // entry to DONE.
  always_comb begin
    nxt_res      = res;
    nxt_res[idx] = add_sum;
  end

  // Core inputs come only from registers and are gated to zero outside RUN.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_l[idx];
      add_b   = b_l[idx];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_l      <= '0;
      b_l      <= '0;
      res      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_l   <= in_a;
          // Subtract as A + ~B + 1: invert B once here, force carry-in.
          b_l   <= in_sub ? ~in_b : in_b;
          carry <= in_sub | in_cin;
          idx   <= '0;
          res   <= '0;
          state <= RUN;
        end
        RUN: begin
          res   <= nxt_res;
          carry <= add_cout;
          if (last) begin
            out_sum  <= nxt_res;
            out_cout <= add_cout;
            // Overflow: operands (B already inverted) share a sign that
            // differs from the result sign.
            out_ovf  <= (a_l[LIMBS-1][15] == b_l[LIMBS-1][15]) &&
                        (add_sum[15] != a_l[LIMBS-1][15]);
            idx      <= '0;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bk_limb_seq_adder.sv
module tb_bk_limb_seq_adder;
  localparam int LIMBS = 4;
  localparam int W     = 16*LIMBS;

  logic         clk = 1'b0, rst = 1'b0;
  logic         in_valid = 1'b0, in_ready, in_cin = 1'b0, in_sub = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         out_valid, out_ready = 1'b0, out_cout, out_ovf;
  logic [W-1:0] out_sum;
  logic [15:0]  add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  int nchk = 0, nfail = 0;

  bk_limb_seq_adder #(.LIMBS(LIMBS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // 16-bit adder core stand-in
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  always #5 clk = ~clk;

  // Reference: whole-width arithmetic; returns {ovf, cout, sum}
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, b, input logic cin, sub);
    logic [W:0] full;
    logic ovf;
    if (sub) begin
      full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    end
    return {ovf, full};
  endfunction

  // Full transaction from IDLE: accept, measure latency, check, hand off.
  task automatic run_op(input logic [W-1:0] a, b, input logic cin, sub, input string nm);
    logic [W+1:0] exp;
    int n;
    exp = ref_op(a, b, cin, sub);
    nchk++;
    if (in_ready !== 1'b1) begin nfail++; $display("FAIL %s in_ready: got %b want 1", nm, in_ready); end
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    nchk++;
    if (n !== LIMBS) begin nfail++; $display("FAIL %s latency: got %0d want %0d", nm, n, LIMBS); end
    nchk++;
    if (out_sum !== exp[W-1:0]) begin nfail++; $display("FAIL %s sum: got %h want %h", nm, out_sum, exp[W-1:0]); end
    nchk++;
    if (out_cout !== exp[W]) begin nfail++; $display("FAIL %s cout: got %b want %b", nm, out_cout, exp[W]); end
    nchk++;
    if (out_ovf !== exp[W+1]) begin nfail++; $display("FAIL %s ovf: got %b want %b", nm, out_ovf, exp[W+1]); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== exp[W-1:0]) begin
      nfail++; $display("FAIL %s handoff: valid=%b ready=%b sum=%h want 0/1/%h", nm, out_valid, in_ready, out_sum, exp[W-1:0]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; #1;
    nchk++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      nfail++; $display("FAIL reset outputs: valid=%b sum=%h cout=%b ovf=%b want all 0", out_valid, out_sum, out_cout, out_ovf);
    end
    nchk++;
    if (add_a !== 16'd0 || add_b !== 16'd0 || add_cin !== 1'b0) begin
      nfail++; $display("FAIL reset core ports: a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    nchk++;
    if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, "add_wrap");
    run_op(64'h5, 64'h7, 1'b0, 1'b0 | 1'b1, "sub_borrow");
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, "add_ovf");
    run_op(64'h0000_0000_0001_FFFF, 64'h0, 1'b1, 1'b0, "carry_chain");
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, "sub_ovf_cin_ignored");
    // spot-check the spec's stated values on top of the model
    run_op(64'h5, 64'h7, 1'b0, 1'b1, "sub_abs");
    nchk++;
    if (out_sum !== 64'hFFFF_FFFF_FFFF_FFFE || out_cout !== 1'b0) begin
      nfail++; $display("FAIL sub_abs const: got %h/%b want fffffffffffffffe/0", out_sum, out_cout);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = {$urandom, $urandom};
      b = (i % 4 == 0) ? ~a : {$urandom, $urandom};
      run_op(a, b, 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_backpressure;
    logic [W+1:0] exp;
    int n;
    exp = ref_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h0FED_CBA9_8765_4321; in_cin = 1'b1; in_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = {$urandom, $urandom};  // in_valid stays high with new operands
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      nchk++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== exp[W-1:0] ||
          out_cout !== exp[W] || out_ovf !== exp[W+1] || add_a !== 16'd0 || add_cin !== 1'b0) begin
        nfail++;
        $display("FAIL stall cyc%0d: valid=%b ready=%b sum=%h cout=%b ovf=%b add_a=%h want 1/0/%h/%b/%b/0",
                 c, out_valid, in_ready, out_sum, out_cout, out_ovf, add_a, exp[W-1:0], exp[W], exp[W+1]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    nchk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      nfail++; $display("FAIL stall release: valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cin = 1'b0; in_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;   // now processing limb 2
    nchk++;
    if (add_a !== in_a[47:32]) begin nfail++; $display("FAIL midrun limb2: got %h want %h", add_a, in_a[47:32]); end
    rst = 1'b1; #1;
    nchk++;
    if (out_valid !== 1'b0 || add_a !== 16'd0 || add_b !== 16'd0 || add_cin !== 1'b0 || out_sum !== '0) begin
      nfail++; $display("FAIL async reset: valid=%b a=%h b=%h cin=%b sum=%h want all 0", out_valid, add_a, add_b, add_cin, out_sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, "post_reset");
  endtask

  task automatic test_back_to_back;
    logic [W+1:0] q[$];
    logic [W+1:0] exp;
    int last_hand = -1, nhand = 0;
    logic acc, hand;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    in_cin = 1'($urandom); in_sub = 1'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc  = in_valid && in_ready;
      hand = out_valid && out_ready;
      if (acc) q.push_back(ref_op(in_a, in_b, in_cin, in_sub));
      if (hand) begin
        nchk++;
        if (q.size() == 0) begin
          nfail++; $display("FAIL b2b spurious result: got %h want none", out_sum);
        end else begin
          exp = q.pop_front();
          if (out_sum !== exp[W-1:0] || out_cout !== exp[W] || out_ovf !== exp[W+1]) begin
            nfail++; $display("FAIL b2b result: got %h/%b/%b want %h/%b/%b", out_sum, out_cout, out_ovf, exp[W-1:0], exp[W], exp[W+1]);
          end
        end
        if (last_hand >= 0) begin
          nchk++;
          if (cyc - last_hand !== LIMBS + 2) begin
            nfail++; $display("FAIL b2b spacing: got %0d want %0d", cyc - last_hand, LIMBS + 2);
          end
        end
        last_hand = cyc;
        nhand++;
      end
      @(posedge clk); #1;
      if (acc) begin
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
        in_cin = 1'($urandom); in_sub = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    nchk++;
    if (nhand < 5) begin nfail++; $display("FAIL b2b handoffs: got %0d want >=5", nhand); end
    while (out_valid !== 1'b1 && in_ready !== 1'b1) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
